// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop, LSB first over WIDTH cycles.
// Define SERIAL_ADDER_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_adder_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, acc;
  logic [CW-1:0]    count;
  logic             carry;
  logic             bit_s, carry_next, last_bit, accept;

  assign bit_s      = op_a[0] ^ op_b[0] ^ carry;
  assign carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  assign last_bit   = (count == CW'(WIDTH - 1));
  assign accept     = start && ((state == IDLE) || (state == DONE));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = accept ? RUN : IDLE;
      RUN:        if (last_bit) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + (1 ^ borrow_in), so the inverted B and carry are fixed at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      count <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= cin ^ sub;
      count <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      carry <= carry_next;
      acc   <= {bit_s, acc[WIDTH-1:1]};
      if (!last_bit) begin
        count <= count + 1'b1;
      end else begin
        sum  <= {bit_s, acc[WIDTH-1:1]};
        cout <= carry_next;
`ifdef SERIAL_ADDER_SUB_OVF_EN
        // carry still holds the carry into the MSB slice during the last bit
        ovf  <= carry ^ carry_next;
`endif
      end
    end
  end

endmodule
